// File: rtl/temp_sample_ctrl.sv
// Periodic temperature sampler: requests a read from the I2C master, converts the
// result to clamped Celsius/Fahrenheit display values. Optional TEMP_AVG_EN adds a 4-sample average.
module temp_sample_ctrl #(
   parameter int SAMPLE_PERIOD  = 25_000_000,
   parameter int TIMEOUT_CYCLES = 250_000
) (
   input  logic       clk_25MHz,
   input  logic       rst_n,
   output logic       rd_req,
   input  logic       rd_ack,
   input  logic [7:0] rd_data,
   input  logic       rd_err,
   output logic [7:0] c_data,
   output logic [7:0] f_data,
   output logic       data_valid,
   output logic       err_flag
);

   localparam int WW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, CONV, WAIT} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    sample;
   logic [6:0]    cl_new;
   logic [6:0]    cl;
   logic [10:0]   f_full;
   logic [7:0]    f_sat;

`ifdef TEMP_AVG_EN
   logic [6:0] hist     [4];
   logic [6:0] hist_nxt [4];
   logic [8:0] hist_sum;
`endif

   always_comb begin
      cl_new = 7'd0;
      if (sample[7])
         cl_new = 7'd0;
      else if (sample > 8'd99)
         cl_new = 7'd99;
      else
         cl_new = sample[6:0];
`ifdef TEMP_AVG_EN
      // First good sample after reset seeds the whole history so the average starts flat.
      for (int i = 0; i < 4; i++) hist_nxt[i] = cl_new;
      if (data_valid) begin
         hist_nxt[1] = hist[0];
         hist_nxt[2] = hist[1];
         hist_nxt[3] = hist[2];
      end
      hist_sum = 9'(hist_nxt[0]) + 9'(hist_nxt[1]) + 9'(hist_nxt[2]) + 9'(hist_nxt[3]);
      cl = 7'(hist_sum >> 2);
`else
      cl = cl_new;
`endif
      f_full = (({4'd0, cl} * 11'd9) / 11'd5) + 11'd32;
      f_sat  = (f_full > 11'd99) ? 8'd99 : f_full[7:0];
   end

   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_req     <= 1'b0;
         c_data     <= 8'd0;
         f_data     <= 8'd0;
         data_valid <= 1'b0;
         err_flag   <= 1'b0;
         wait_cnt   <= '0;
         to_cnt     <= '0;
         sample     <= 8'd0;
`ifdef TEMP_AVG_EN
         hist       <= '{default: '0};
`endif
      end else begin
         case (state)
            IDLE: begin
               state    <= REQ;
               rd_req   <= 1'b1;
               wait_cnt <= '0;
               to_cnt   <= '0;
            end
            REQ: begin
               // An ack in the same cycle as the timeout wins.
               if (rd_ack) begin
                  rd_req   <= 1'b0;
                  wait_cnt <= '0;
                  to_cnt   <= '0;
                  if (rd_err) begin
                     state    <= WAIT;
                     err_flag <= 1'b1;
                  end else begin
                     state  <= CONV;
                     sample <= rd_data;
                  end
               end else if (to_cnt == T_LAST) begin
                  state    <= WAIT;
                  rd_req   <= 1'b0;
                  err_flag <= 1'b1;
                  wait_cnt <= '0;
                  to_cnt   <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            CONV: begin
               state      <= WAIT;
               c_data     <= {1'b0, cl};
               f_data     <= f_sat;
               data_valid <= 1'b1;
               err_flag   <= 1'b0;
               wait_cnt   <= '0;
               to_cnt     <= '0;
`ifdef TEMP_AVG_EN
               hist       <= hist_nxt;
`endif
            end
            WAIT: begin
               if (wait_cnt == W_LAST) begin
                  state    <= REQ;
                  rd_req   <= 1'b1;
                  wait_cnt <= '0;
                  to_cnt   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               rd_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Scoreboard bench for temp_sample_ctrl (SAMPLE_PERIOD=10, TIMEOUT_CYCLES=5).
module tb_temp_sample_ctrl;
   localparam int SP = 10;
   localparam int TO = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd_req;
   logic       rd_ack = 1'b0;
   logic [7:0] rd_data = 8'd0;
   logic       rd_err = 1'b0;
   logic [7:0] c_data, f_data;
   logic       data_valid, err_flag;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] c;
      logic [7:0] f;
      logic       v;
      logic       e;
   } exp_t;

   exp_t sb[$];
   logic [7:0] m_c = 8'd0, m_f = 8'd0;
   logic       m_v = 1'b0, m_e = 1'b0;
   int         m_hist[4];

   always #20 clk = ~clk;

   temp_sample_ctrl #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO)) dut (
      .clk_25MHz (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .rd_err    (rd_err),
      .c_data    (c_data),
      .f_data    (f_data),
      .data_valid(data_valid),
      .err_flag  (err_flag)
   );

   // Reference model: expected display state after a read attempt.
   task automatic model_push(input logic [7:0] d, input logic bad);
      int   cl;
      int   f;
      exp_t x;
      if (bad) begin
         m_e = 1'b1;
      end else begin
         if ($signed(d) < 0) cl = 0;
         else if ($signed(d) > 99) cl = 99;
         else cl = int'($signed(d));
`ifdef TEMP_AVG_EN
         if (!m_v) begin
            for (int i = 0; i < 4; i++) m_hist[i] = cl;
         end else begin
            m_hist[3] = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = cl;
         end
         cl = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`endif
         f   = (cl * 9) / 5 + 32;
         if (f > 99) f = 99;
         m_c = 8'(cl);
         m_f = 8'(f);
         m_v = 1'b1;
         m_e = 1'b0;
      end
      x.c = m_c; x.f = m_f; x.v = m_v; x.e = m_e;
      sb.push_back(x);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!rd_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rd_req) begin
         checks++;
         errors++;
         $display("FAIL wait_req: rd_req never rose within %0d cycles", n);
      end
   endtask

   // Waits for a request, acks it after 'delay' REQ cycles; returns at the cycle after the ack.
   task automatic do_read(input logic [7:0] d, input logic err, input int delay, output logic req_after);
      int n;
      wait_req(n);
      repeat (delay) @(negedge clk);
      rd_ack  = 1'b1;
      rd_data = d;
      rd_err  = err;
      model_push(d, err);
      @(negedge clk);
      req_after = rd_req;
      rd_ack  = 1'b0;
      rd_err  = 1'b0;
      rd_data = 8'h55;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd_req, c_data, f_data, data_valid, err_flag} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state: got req=%0b c=%0d f=%0d v=%0b e=%0b, want all 0",
                  rd_req, c_data, f_data, data_valid, err_flag);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_req: got %0b want 1", rd_req);
      end
   endtask

   task automatic test_basic;
      logic req_after;
      exp_t x;
      int   n;
      do_read(8'd25, 1'b0, 2, req_after);
      checks++;
      if (req_after !== 1'b0) begin
         errors++;
         $display("FAIL basic_req_drop: got %0b want 0", req_after);
      end
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
         errors++;
         $display("FAIL basic_out: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=%0b",
                  c_data, f_data, data_valid, err_flag, x.c, x.f, x.v, x.e);
      end
      checks++;
      if (c_data !== 8'd25 || f_data !== 8'd77) begin
         errors++;
         $display("FAIL basic_const: got c=%0d f=%0d want c=25 f=77", c_data, f_data);
      end
      n = 0;
      while (!rd_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== SP) begin
         errors++;
         $display("FAIL basic_wait_len: got %0d want %0d", n, SP);
      end
   endtask

   task automatic test_clamp;
      logic [7:0] vals[4];
      logic       req_after;
      exp_t       x;
      vals[0] = 8'd37; vals[1] = 8'd38; vals[2] = 8'hF6; vals[3] = 8'd120;
      for (int i = 0; i < 4; i++) begin
         do_read(vals[i], 1'b0, 1, req_after);
         @(negedge clk);
         x = sb.pop_front();
         checks++;
         if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
            errors++;
            $display("FAIL clamp_%0d: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=%0b",
                     vals[i], c_data, f_data, data_valid, err_flag, x.c, x.f, x.v, x.e);
         end
      end
   endtask

   task automatic test_timeout;
      int   n;
      logic req_after;
      exp_t x;
      wait_req(n);
      model_push(8'd0, 1'b1);
      n = 0;
      while (rd_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== TO) begin
         errors++;
         $display("FAIL timeout_len: got %0d want %0d", n, TO);
      end
      x = sb.pop_front();
      checks++;
      if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
         errors++;
         $display("FAIL timeout_out: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=%0b",
                  c_data, f_data, data_valid, err_flag, x.c, x.f, x.v, x.e);
      end
      do_read(8'd30, 1'b0, 0, req_after);
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e} || err_flag !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=0",
                  c_data, f_data, data_valid, err_flag, x.c, x.f, x.v);
      end
   endtask

   task automatic test_err_wait_ack;
      logic req_after;
      exp_t x;
      int   n;
      do_read(8'd55, 1'b1, 1, req_after);
      checks++;
      if (req_after !== 1'b0) begin
         errors++;
         $display("FAIL err_req_drop: got %0b want 0", req_after);
      end
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
         errors++;
         $display("FAIL err_out: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=%0b",
                  c_data, f_data, data_valid, err_flag, x.c, x.f, x.v, x.e);
      end
      // Stray ack while waiting must be ignored entirely.
      rd_ack = 1'b1; rd_data = 8'd50; rd_err = 1'b0;
      @(negedge clk);
      rd_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({rd_req, c_data, f_data, data_valid, err_flag} !== {1'b0, m_c, m_f, m_v, m_e}) begin
         errors++;
         $display("FAIL wait_ack_ignored: got req=%0b c=%0d f=%0d v=%0b e=%0b want req=0 c=%0d f=%0d v=%0b e=%0b",
                  rd_req, c_data, f_data, data_valid, err_flag, m_c, m_f, m_v, m_e);
      end
      n = 0;
      while (!rd_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== SP - 3) begin
         errors++;
         $display("FAIL wait_ack_period: got %0d want %0d", n, SP - 3);
      end
   endtask

   task automatic test_ack_on_timeout;
      logic req_after;
      exp_t x;
      do_read(8'd40, 1'b0, TO - 1, req_after);
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
         errors++;
         $display("FAIL ack_at_timeout: got c=%0d f=%0d v=%0b e=%0b want c=%0d f=%0d v=%0b e=%0b",
                  c_data, f_data, data_valid, err_flag, x.c, x.f, x.v, x.e);
      end
   endtask

   task automatic test_reset_mid_req;
      int n;
      wait_req(n);
      rd_ack = 1'b1; rd_data = 8'd77; rd_err = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      checks++;
      if ({rd_req, c_data, f_data, data_valid, err_flag} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid_req: got req=%0b c=%0d f=%0d v=%0b e=%0b want all 0",
                  rd_req, c_data, f_data, data_valid, err_flag);
      end
      rd_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_c = 8'd0; m_f = 8'd0; m_v = 1'b0; m_e = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
      sb.delete();
      @(negedge clk);
      checks++;
      if (rd_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_req_restart: got %0b want 1", rd_req);
      end
   endtask

`ifdef TEMP_AVG_EN
   task automatic test_avg;
      logic [7:0] vals[4];
      logic       req_after;
      exp_t       x;
      vals[0] = 8'd20; vals[1] = 8'd20; vals[2] = 8'd20; vals[3] = 8'd24;
      for (int i = 0; i < 4; i++) begin
         do_read(vals[i], 1'b0, 1, req_after);
         @(negedge clk);
         x = sb.pop_front();
         checks++;
         if ({c_data, f_data, data_valid, err_flag} !== {x.c, x.f, x.v, x.e}) begin
            errors++;
            $display("FAIL avg_%0d: got c=%0d f=%0d want c=%0d f=%0d", i, c_data, f_data, x.c, x.f);
         end
      end
      checks++;
      if (c_data !== 8'd21 || f_data !== 8'd69) begin
         errors++;
         $display("FAIL avg_const: got c=%0d f=%0d want c=21 f=69", c_data, f_data);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
      test_reset;
      test_basic;
      test_clamp;
      test_timeout;
      test_err_wait_ack;
      test_ack_on_timeout;
      test_reset_mid_req;
`ifdef TEMP_AVG_EN
      test_avg;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 25_000_000, cycles spent in WAIT between reads (1 s at 25 MHz); legal range >= 1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250_000, the maximum number of cycles in REQ without rd_ack (10 ms); legal range >= 1.
REQ-003 SHALL have port clk_25MHz  input  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rd_req  output  1  level request to the I2C temperature master.
REQ-006 SHALL have port rd_ack  input  1  one-cycle pulse: read complete, rd_data and rd_err valid.
REQ-007 SHALL have port rd_data  input  8  temperature in °C, signed two's complement integer.
REQ-008 SHALL have port rd_err  input  1  bus error (NACK) for the read completed with rd_ack.
REQ-009 SHALL have port c_data  output  8  display Celsius, unsigned, range 0..99.
REQ-010 SHALL have port f_data  output  8  display Fahrenheit, unsigned, range 0..99.
REQ-011 SHALL have port data_valid  output  1  high once at least one good sample has been published.
REQ-012 SHALL have port err_flag  output  1  high while the most recent read attempt failed.

Function
REQ-013 SHALL implement the FSM states IDLE, REQ, CONV and WAIT.
REQ-014 SHALL move IDLE -> REQ unconditionally on the first cycle after reset release.
REQ-015 SHALL hold rd_req high for exactly every cycle the FSM is in REQ, and low in all other states.
REQ-016 SHALL, in REQ, move REQ -> CONV on rd_ack=1 with rd_err=0.
REQ-017 SHALL, in REQ, move REQ -> WAIT and set err_flag on rd_ack=1 with rd_err=1.
REQ-018 SHALL, in REQ, move REQ -> WAIT and set err_flag after TIMEOUT_CYCLES consecutive REQ cycles without rd_ack.
REQ-019 SHALL give rd_ack priority when rd_ack arrives in the same cycle the timeout expires.
REQ-020 SHALL ignore rd_ack, rd_err and rd_data in any state other than REQ.
REQ-021 SHALL capture rd_data in the cycle rd_ack is accepted.
REQ-022 SHALL clamp the captured sample to cl = 0 if negative, cl = 99 if above 99, and leave it unchanged otherwise.
REQ-023 SHALL compute f = floor(cl*9/5) + 32 with an intermediate of at least 10 bits, saturating f at 99.
REQ-024 SHALL stay in CONV for exactly one cycle; c_data, f_data and data_valid=1 update at the end of CONV, and err_flag clears at the same time.
REQ-025 SHALL hold c_data and f_data at their last good values on an error or timeout.
REQ-026 SHALL make the latency from an accepted rd_ack (cycle N) to updated outputs cycle N+2; rd_req is low from cycle N+1.
REQ-027 SHALL remain in WAIT for exactly SAMPLE_PERIOD cycles and then enter REQ.
REQ-028 SHALL clear the wait counter and the timeout counter on every state entry.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set the state to IDLE, rd_req=0, c_data=0, f_data=0, data_valid=0, err_flag=0, and clear all counters and history.
REQ-030 SHALL, when reset is asserted mid-REQ, drop rd_req on the next edge and ignore any rd_ack arriving during reset.

Configuration
REQ-031 SHALL, when macro TEMP_AVG_EN is defined, keep a 4-entry history of clamped good samples.
REQ-032 SHALL, with TEMP_AVG_EN defined, load all 4 history entries with the first good sample after reset.
REQ-033 SHALL, with TEMP_AVG_EN defined, set cl = (sum of the 4 entries) >> 2, truncated, and derive c_data and f_data from that cl.
REQ-034 SHALL, with TEMP_AVG_EN defined, leave the history unchanged on errors.
REQ-035 SHALL, when TEMP_AVG_EN is undefined, use the latest clamped sample directly, with no history storage present.

Verification (SAMPLE_PERIOD=10, TIMEOUT_CYCLES=5, TEMP_AVG_EN undefined unless stated)
REQ-036 SHALL cover: reset release, ack 2 cycles after rd_req with rd_data=25 -> rd_req falls next cycle; two cycles after ack c_data=25, f_data=77, data_valid=1; next rd_req exactly 10 cycles after entering WAIT.
REQ-037 SHALL cover: rd_data=37 -> f_data=98; rd_data=38 -> f_data=99 (saturated); rd_data=8'hF6 (-10) -> c_data=0, f_data=32; rd_data=120 -> c_data=99, f_data=99.
REQ-038 SHALL cover: no rd_ack for 5 REQ cycles -> rd_req falls, err_flag=1, c_data and f_data unchanged; next good read -> err_flag=0.
REQ-039 SHALL cover: rd_ack=1 with rd_err=1 -> err_flag=1, outputs held; rd_ack pulsed during WAIT -> no state or output change.
REQ-040 SHALL cover: rd_ack coincident with the 5th REQ cycle -> sample accepted, err_flag=0.
REQ-041 SHALL cover: rst_n low while rd_req high -> rd_req=0 and all outputs 0 on the next edge; with TEMP_AVG_EN defined, samples 20,20,20,24 -> c_data=21, f_data=69.
